// File: rtl/gfp_arith_unit.sv
// GF(p) arithmetic unit: ADD, SUB, MUL (double-and-add), DIV (binary inversion) behind a start/busy/done handshake.
// Optional operand range check at start is built when GFP_RANGE_CHECK_EN is defined.
module gfp_arith_unit #(
   parameter int WIDTH   = 32,
   parameter int DIV_MAX = 4 * WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_prime,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [WIDTH-1:0] o_result
);

   localparam int CW = $clog2(DIV_MAX + WIDTH + 2);
   localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH);
   localparam logic [CW-1:0]    DIV_LAST = CW'(DIV_MAX);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_e;
   typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_DONE} state_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, acc_q, acc_d;
   logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             start_ok;
   logic             start_range_err;
   logic             range_err_q;
   logic [WIDTH-1:0] mul_next;

   assign start_ok = (state_q == S_IDLE) && i_start;

`ifdef GFP_RANGE_CHECK_EN
   assign start_range_err = (i_a >= i_prime) || (i_b >= i_prime);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         range_err_q <= 1'b0;
      end else if (start_ok) begin
         range_err_q <= start_range_err;
      end
   end
`else
   assign start_range_err = 1'b0;
   assign range_err_q     = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, y, p);
      logic [WIDTH:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, p}) s = s - {1'b0, p};
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, y, p);
      logic [WIDTH:0] s;
      if (x >= y) s = {1'b0, x} - {1'b0, y};
      else        s = {1'b0, x} + {1'b0, p} - {1'b0, y};
      return s[WIDTH-1:0];
   endfunction

   // Exact halving mod p: an odd x becomes even once p (odd) is added.
   function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x, p);
      logic [WIDTH:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
      return s[WIDTH:1];
   endfunction

   // One double-and-add step; b_q is shifted left so its MSB is the current bit.
   always_comb begin
      logic [WIDTH+1:0] dbl, sum;
      dbl = {1'b0, acc_q, 1'b0};
      if (dbl >= {2'b00, p_q}) dbl = dbl - {2'b00, p_q};
      sum = dbl + {2'b00, a_q};
      if (sum >= {2'b00, p_q}) sum = sum - {2'b00, p_q};
      mul_next = b_q[WIDTH-1] ? sum[WIDTH-1:0] : dbl[WIDTH-1:0];
   end

   // NOTE: every _d starts as a hold of its _q so no path through the case leaves a latch behind.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      p_d      = p_q;
      acc_d    = acc_q;
      u_d      = u_q;
      v_d      = v_q;
      x1_d     = x1_q;
      x2_d     = x2_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               op_d     = op_e'(i_op);
               a_d      = i_a;
               b_d      = i_b;
               p_d      = i_prime;
               acc_d    = '0;
               u_d      = i_b;
               v_d      = i_prime;
               x1_d     = i_a;
               x2_d     = '0;
               cnt_d    = '0;
               result_d = '0;
               err_d    = 1'b0;
               if (start_range_err) begin
                  state_d = S_ADDSUB;
               end else begin
                  case (op_e'(i_op))
                     OP_ADD, OP_SUB: state_d = S_ADDSUB;
                     OP_MUL:         state_d = S_MUL;
                     default:        state_d = S_DIV;
                  endcase
               end
            end
         end

         // Also the landing state for a range error, so that path keeps the two-cycle latency.
         S_ADDSUB: begin
            if (range_err_q) begin
               result_d = '0;
               err_d    = 1'b1;
            end else if (op_q == OP_SUB) begin
               result_d = sub_mod(a_q, b_q, p_q);
            end else begin
               result_d = add_mod(a_q, b_q, p_q);
            end
            state_d = S_DONE;
         end

         S_MUL: begin
            if (cnt_q == MUL_LAST) begin
               result_d = acc_q;
               state_d  = S_DONE;
            end else begin
               acc_d = mul_next;
               b_d   = b_q << 1;
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DIV: begin
            if (u_q == '0) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_DONE;
            end else if (u_q == ONE || v_q == ONE) begin
               result_d = (u_q == ONE) ? x1_q : x2_q;
               state_d  = S_DONE;
            end else if (cnt_q == DIV_LAST) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_DONE;
            end else begin
               if (!u_q[0]) begin
                  u_d  = u_q >> 1;
                  x1_d = halve_mod(x1_q, p_q);
               end else if (!v_q[0]) begin
                  v_d  = v_q >> 1;
                  x2_d = halve_mod(x2_q, p_q);
               end else if (u_q >= v_q) begin
                  u_d  = u_q - v_q;
                  x1_d = sub_mod(x1_q, x2_q, p_q);
               end else begin
                  v_d  = v_q - u_q;
                  x2_d = sub_mod(x2_q, x1_q, p_q);
               end
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         p_q      <= '0;
         acc_q    <= '0;
         u_q      <= '0;
         v_q      <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         p_q      <= p_d;
         acc_q    <= acc_d;
         u_q      <= u_d;
         v_q      <= v_d;
         x1_q     <= x1_d;
         x2_q     <= x2_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (state_q)
         S_ADDSUB, S_MUL, S_DIV: o_busy = 1'b1;
         S_DONE:                 o_done = 1'b1;
         default:                ;
      endcase
   end

   assign o_result = result_q;
   assign o_err    = err_q;

endmodule

// File: tb/tb_gfp_arith_unit.sv
// Scoreboard bench for gfp_arith_unit: an 8-bit and a 32-bit instance checked against a Fermat-inverse model.
// Define GFP_RANGE_CHECK_EN for both files to also exercise the operand range check.
module tb_gfp_arith_unit;

   localparam int W8 = 8;
   localparam int W32 = 32;
   localparam int MAX8 = 4 * W8;
   localparam int MAX32 = 4 * W32;
   localparam longint unsigned P8  = 251;
   localparam longint unsigned P32 = 64'hFFFF_FFFB;
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
   localparam int WAIT_MAX = 300;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst8, start8, busy8, done8, err8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, p8, res8;
   logic        rst32, start32, busy32, done32, err32;
   logic [1:0]  op32;
   logic [31:0] a32, b32, p32, res32;

   gfp_arith_unit #(.WIDTH(W8), .DIV_MAX(MAX8)) dut8 (
      .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_op(op8),
      .i_a(a8), .i_b(b8), .i_prime(p8),
      .o_busy(busy8), .o_done(done8), .o_err(err8), .o_result(res8)
   );

   gfp_arith_unit #(.WIDTH(W32), .DIV_MAX(MAX32)) dut32 (
      .i_clk(clk), .i_rst(rst32), .i_start(start32), .i_op(op32),
      .i_a(a32), .i_b(b32), .i_prime(p32),
      .o_busy(busy32), .o_done(done32), .o_err(err32), .o_result(res32)
   );

   longint unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string           tag;
      longint unsigned res;
      bit              err;
      int              lat;
      int              max_lat;
      longint unsigned t0;
   } exp_t;

   exp_t q8[$];
   exp_t q32[$];
   exp_t m8, m32;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint unsigned mod_pow(input longint unsigned base, input longint unsigned e,
                                               input longint unsigned p);
      longint unsigned r = 1;
      longint unsigned x = base % p;
      while (e != 0) begin
         if (e[0]) r = (r * x) % p;
         x = (x * x) % p;
         e = e >> 1;
      end
      return r;
   endfunction

   function automatic longint unsigned model(input logic [1:0] op, input longint unsigned a,
                                             input longint unsigned b, input longint unsigned p,
                                             output bit err);
      err = 1'b0;
      case (op)
         OP_ADD:  return (a + b) % p;
         OP_SUB:  return (a + p - b) % p;
         OP_MUL:  return (a * b) % p;
         default: begin
            if (b == 0) begin
               err = 1'b1;
               return 0;
            end
            return (a * mod_pow(b, p - 2, p)) % p;
         end
      endcase
   endfunction

   // Latency is counted in rising edges from the accept edge to the edge entering DONE.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         check("done8_expected", q8.size() != 0, 1);
         check("busy8_in_done", busy8, 0);
         if (q8.size() != 0) begin
            m8 = q8.pop_front();
            check({m8.tag, "_res"}, res8, m8.res);
            check({m8.tag, "_err"}, err8, m8.err);
            if (m8.lat >= 0) check({m8.tag, "_lat"}, cyc - m8.t0, m8.lat);
            else check({m8.tag, "_lat_bound"}, (cyc - m8.t0 >= 2) && (cyc - m8.t0 <= m8.max_lat), 1);
         end
      end
   end

   always @(negedge clk) begin
      if (done32 === 1'b1) begin
         check("done32_expected", q32.size() != 0, 1);
         check("busy32_in_done", busy32, 0);
         if (q32.size() != 0) begin
            m32 = q32.pop_front();
            check({m32.tag, "_res"}, res32, m32.res);
            check({m32.tag, "_err"}, err32, m32.err);
            if (m32.lat >= 0) check({m32.tag, "_lat"}, cyc - m32.t0, m32.lat);
            else check({m32.tag, "_lat_bound"}, (cyc - m32.t0 >= 2) && (cyc - m32.t0 <= m32.max_lat), 1);
         end
      end
   end

   // Called at a negedge while the DUT is idle; start is held across exactly one rising edge.
   task automatic issue(input bit big, input string tag, input logic [1:0] op,
                        input longint unsigned a, input longint unsigned b, input longint unsigned p,
                        input longint unsigned exp_res, input bit exp_err, input int exp_lat);
      exp_t e;
      e.tag = tag;
      e.res = exp_res;
      e.err = exp_err;
      e.lat = exp_lat;
      e.max_lat = big ? MAX32 + 2 : MAX8 + 2;
      e.t0 = cyc;
      if (big) begin
         q32.push_back(e);
         op32 = op; a32 = a[31:0]; b32 = b[31:0]; p32 = p[31:0]; start32 = 1'b1;
      end else begin
         q8.push_back(e);
         op8 = op; a8 = a[7:0]; b8 = b[7:0]; p8 = p[7:0]; start8 = 1'b1;
      end
      @(negedge clk);
      start8  = 1'b0;
      start32 = 1'b0;
   endtask

   task automatic issue_m(input bit big, input string tag, input logic [1:0] op,
                          input longint unsigned a, input longint unsigned b, input longint unsigned p);
      bit              err;
      longint unsigned res;
      int              lat;
      res = model(op, a, b, p, err);
      case (op)
         OP_ADD, OP_SUB: lat = 2;
         OP_MUL:         lat = (big ? W32 : W8) + 2;
         default:        lat = -1;
      endcase
      issue(big, tag, op, a, b, p, res, err, lat);
   endtask

   task automatic wait_idle(input bit big);
      int n = 0;
      while ((big ? q32.size() : q8.size()) != 0 && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      check(big ? "timeout32" : "timeout8", n < WAIT_MAX, 1);
      @(negedge clk);
      check(big ? "done32_pulse" : "done8_pulse", big ? done32 : done8, 0);
   endtask

   initial begin
      longint unsigned ra, rb, rp;
      logic [1:0]      rop;
      rst8 = 1'b1; rst32 = 1'b1; start8 = 1'b0; start32 = 1'b0;
      op8 = '0; a8 = '0; b8 = '0; p8 = '0;
      op32 = '0; a32 = '0; b32 = '0; p32 = '0;
      repeat (3) @(negedge clk);
      rst8 = 1'b0; rst32 = 1'b0;
      @(negedge clk);
      check("rst_busy8", busy8, 0);   check("rst_done8", done8, 0);
      check("rst_err8", err8, 0);     check("rst_res8", res8, 0);
      check("rst_busy32", busy32, 0); check("rst_done32", done32, 0);
      check("rst_err32", err32, 0);   check("rst_res32", res32, 0);

      issue_m(0, "add_200_100", OP_ADD, 200, 100, P8); wait_idle(0);
      issue_m(0, "sub_3_10",    OP_SUB, 3, 10, P8);    wait_idle(0);
      issue_m(0, "sub_10_10",   OP_SUB, 10, 10, P8);   wait_idle(0);
      issue_m(0, "mul_17_19",   OP_MUL, 17, 19, P8);   wait_idle(0);
      issue_m(0, "mul_250_250", OP_MUL, 250, 250, P8); wait_idle(0);
      issue_m(0, "div_1_2",     OP_DIV, 1, 2, P8);     wait_idle(0);
      issue_m(0, "div_10_0",    OP_DIV, 10, 0, P8);    wait_idle(0);
      issue_m(0, "add_250_250", OP_ADD, 250, 250, P8); wait_idle(0);
      issue_m(0, "sub_0_250",   OP_SUB, 0, 250, P8);   wait_idle(0);
      issue_m(0, "div_250_250", OP_DIV, 250, 250, P8); wait_idle(0);

      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 2))
            0:       rp = 7;
            1:       rp = 13;
            default: rp = P8;
         endcase
         rop = 2'($urandom_range(0, 3));
         ra  = longint'($urandom_range(0, 32'(rp - 1)));
         rb  = longint'($urandom_range(0, 32'(rp - 1)));
         issue_m(0, "rand8", rop, ra, rb, rp);
         wait_idle(0);
      end

`ifdef GFP_RANGE_CHECK_EN
      issue(0, "range_add_251_1", OP_ADD, 251, 1, P8, 0, 1'b1, 2); wait_idle(0);
      issue(0, "range_mul_b", OP_MUL, 3, 251, P8, 0, 1'b1, 2);     wait_idle(0);
`endif

      // Reset during a multi-step DIV aborts it without a completion pulse.
      issue_m(0, "div_abort", OP_DIV, 7, 3, P8);
      @(negedge clk);
      check("abort_busy_before", busy8, 1);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      q8.delete();
      check("abort_busy", busy8, 0); check("abort_done", done8, 0);
      check("abort_err", err8, 0);   check("abort_res", res8, 0);
      repeat (10) @(negedge clk);
      issue_m(0, "add_after_rst", OP_ADD, 5, 7, P8); wait_idle(0);

      issue_m(1, "mul32_pm1", OP_MUL, P32 - 1, P32 - 1, P32); wait_idle(1);
      issue_m(1, "div32_5_5", OP_DIV, 5, 5, P32);             wait_idle(1);
      issue_m(1, "add32_pm1", OP_ADD, P32 - 1, P32 - 1, P32); wait_idle(1);
      issue_m(1, "sub32_0_1", OP_SUB, 0, 1, P32);             wait_idle(1);
      issue_m(1, "div32_0_b", OP_DIV, 0, 12345, P32);         wait_idle(1);
      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = longint'($urandom) % P32;
         rb  = longint'($urandom) % P32;
         issue_m(1, "rand32", rop, ra, rb, P32);
         wait_idle(1);
      end

      // A second start mid-MUL with different operands must change nothing.
      issue_m(1, "mul32_mid_start", OP_MUL, 123456789, 987654321, P32);
      repeat (5) @(negedge clk);
      op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      wait_idle(1);

      repeat (60) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
